// File: rtl/mm_ss_counter.sv
// Two-field modulo counter (minutes:seconds style) with up/down count, pause,
// manual adjust, clamped preset load and a sticky expiry on down-count to 0:0.
module mm_ss_counter #(
    parameter int LO_MOD = 60,
    parameter int HI_MOD = 60,
    parameter int LO_W   = 6,
    parameter int HI_W   = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            pause,
    input  logic            dir,
    input  logic            load,
    input  logic [LO_W-1:0] load_lo,
    input  logic [HI_W-1:0] load_hi,
    input  logic            adj_en,
    input  logic            adj_sel,
    input  logic            adj_tick,
    output logic [LO_W-1:0] lo,
    output logic [HI_W-1:0] hi,
    output logic            carry,
    output logic            expired,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSE  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [LO_W-1:0] LO_MAX = LO_W'(LO_MOD - 1);
    localparam logic [HI_W-1:0] HI_MAX = HI_W'(HI_MOD - 1);

    state_t cur;

    logic [LO_W-1:0] lo_inc, lo_dec, lo_clamp, step_lo;
    logic [HI_W-1:0] hi_inc, hi_dec, hi_clamp, step_hi;
    logic            step_carry, step_expire;
    state_t          resume;

    assign state = cur;

    // Single-field neighbours; adjust mode uses *_inc alone so no cross-field carry.
    assign lo_inc   = (lo == LO_MAX) ? '0 : lo + 1'b1;
    assign hi_inc   = (hi == HI_MAX) ? '0 : hi + 1'b1;
    assign lo_dec   = (lo == '0) ? LO_MAX : lo - 1'b1;
    assign hi_dec   = (hi == '0) ? HI_MAX : hi - 1'b1;
    assign lo_clamp = (load_lo > LO_MAX) ? LO_MAX : load_lo;
    assign hi_clamp = (load_hi > HI_MAX) ? HI_MAX : load_hi;

    // State to enter when not held in DONE: adjust wins over pause.
    assign resume = adj_en ? ADJUST : (pause ? PAUSE : RUN);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        step_lo     = lo;
        step_hi     = hi;
        step_carry  = 1'b0;
        step_expire = 1'b0;
        if (!dir) begin
            step_lo = lo_inc;
            if (lo == LO_MAX) begin
                step_hi    = hi_inc;
                step_carry = (hi == HI_MAX);
            end
        end else if (lo == '0 && hi == '0) begin
            // Down tick already at 0:0 (e.g. after loading 0:0): hold and expire.
            step_expire = 1'b1;
        end else begin
            step_lo = lo_dec;
            if (lo == '0) begin
                step_hi = hi_dec;
            end
            step_expire = (step_lo == '0) && (step_hi == '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; reset here is
    // synchronous, so it is sampled like any other input on the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            lo      <= '0;
            hi      <= '0;
            carry   <= 1'b0;
            expired <= 1'b0;
            cur     <= RUN;
        end else begin
            carry <= 1'b0;
            if (load) begin
                lo      <= lo_clamp;
                hi      <= hi_clamp;
                expired <= 1'b0;
                cur     <= resume;
            end else if (cur == DONE) begin
                cur <= DONE;
            end else if (adj_en) begin
                cur <= ADJUST;
                if (adj_tick) begin
                    if (adj_sel) begin
                        hi <= hi_inc;
                    end else begin
                        lo <= lo_inc;
                    end
                end
            end else if (pause) begin
                cur <= PAUSE;
            end else begin
                cur <= RUN;
                if (tick) begin
                    lo    <= step_lo;
                    hi    <= step_hi;
                    carry <= step_carry;
                    if (step_expire) begin
                        expired <= 1'b1;
                        cur     <= DONE;
                    end
                end
            end
        end
    end

endmodule
